// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline memory subsystem.
// Holds the response-owner encoding and the default arbiter parameters.
package riscv_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Who the memory read response in the next cycle belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage : riscv_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch port (I, read only) and the load/store port (D).
// D has priority; an I requester denied STARVE_LIMIT consecutive cycles
// gains priority for its next request. A low gnt stalls the requester.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request and byte address
//   i_gnt                    fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata         fetch response, cycle after i_gnt
//   d_req/d_we/d_be/d_addr/d_wdata   data request and payload
//   d_gnt                    data access accepted this cycle (combinational)
//   d_rvalid/d_rdata         load response, cycle after d_gnt (loads only)
//   mem_en/we/be/addr/wdata  memory strobe and payload (combinational)
//   mem_rdata                memory read data, cycle after a read strobe
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  owner_e        rsp_owner;
  owner_e        owner_nxt;
  logic          prio_i;
  logic          i_win;
  logic          d_win;

  // Winner selection; nothing is granted while in reset
  always_comb begin
    prio_i = (starve_cnt == CW'(STARVE_LIMIT));
    i_win  = !rst && i_req && (prio_i || !d_req);
    d_win  = !rst && d_req && !i_win;
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  // Memory-side mux; fetches are always full-word reads
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_win) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = i_addr;
    end else if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next starvation count and next response owner
  always_comb begin
    starve_nxt = '0;
    owner_nxt  = OWN_NONE;
    if (i_req && !i_win) begin
      starve_nxt = prio_i ? starve_cnt : starve_cnt + CW'(1);
    end
    if (i_win) begin
      owner_nxt = OWN_I;
    end else if (d_win && !d_we) begin
      owner_nxt = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rsp_owner  <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      rsp_owner  <= owner_nxt;
    end
  end

  // Responses follow the registered owner; a pending response dies in reset
  always_comb begin
    i_rvalid = !rst && (rsp_owner == OWN_I);
    d_rvalid = !rst && (rsp_owner == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the 5-stage pipeline.
- Grants at most one access per cycle and routes the read response back to the owner one cycle later.
- D has priority, with a starvation counter that forces an I grant after a bounded wait.
- Sits between riscv_pipeline_top's IF/MEM stages and the memory array. A deasserted grant is the stall signal for the requesting stage.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, consecutive cycles I may be denied while requesting before it wins priority (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request (read only)
- i_addr  in  XLEN  fetch byte address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid (cycle after i_gnt)
- i_rdata  out  XLEN  fetched word
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_be  in  XLEN/8  byte enables for store
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  d_rdata valid (loads only)
- d_rdata  out  XLEN  load word
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  XLEN/8  memory byte enables
- mem_addr  out  XLEN  memory byte address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Grant decision is combinational from i_req, d_req and the priority flag. Memory-side outputs are combinational from the winner. All response outputs are registered.
- Priority:
  - Default: D wins whenever d_req=1.
  - If prio_i=1, I wins whenever i_req=1.
  - The loser sees gnt=0 and must hold its request and payload stable.
- Starvation counter starve_cnt:
  - Increments when i_req=1 and i_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on i_gnt=1 or i_req=0.
  - prio_i = (starve_cnt == STARVE_LIMIT).
- Grant effects:
  - On a grant: mem_en=1, and mem_addr/we/be/wdata come from the winner.
  - An I grant forces mem_we=0 and mem_be=all ones.
  - No request: mem_en=0, and all mem_* outputs are 0.
- Response ownership:
  - Registers rsp_owner ∈ {NONE, I, D}, set each cycle from the read grant.
  - A D store sets NONE; stores complete at d_gnt and produce no d_rvalid.
- Next-cycle outputs:
  - i_rvalid = (rsp_owner==I).
  - d_rvalid = (rsp_owner==D).
  - The owner's rdata = mem_rdata. The non-owner's rdata = 0.
- Latency: 1 cycle from gnt to rvalid. Throughput: one access per cycle, with back-to-back grants to either or alternating requesters allowed.
- Simultaneous events:
  - Both requesting with prio_i=0: D granted, starve_cnt++.
  - Both requesting with prio_i=1: I granted, starve_cnt cleared, D stalls exactly one cycle.
- Reset:
  - rsp_owner=NONE and starve_cnt=0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en and mem_we are 0 while rst=1.
  - i_rdata and d_rdata are 0.
  - Reset mid-operation discards any pending response, with no rvalid in the cycle after reset.
- Requests for addresses are not checked for alignment. Alignment is the requester's responsibility.

Decomposition:
- Shared package riscv_pkg adds:
  - owner encoding constants OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2
  - default STARVE_LIMIT
- No sub-module. The counter and the response register are small and stay inline.

Test Plan:
- Reset, then i_req=1 with i_addr=0x0 and mem holding 0x00500093 at 0x0:
  - i_gnt=1 in cycle 0.
  - i_rvalid=1 with i_rdata=0x00500093 in cycle 1.
  - d_* outputs remain 0.
- d_req=1 with d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF:
  - mem_we=1 and mem_be=4'b0011 that cycle, no d_rvalid afterwards.
  - A subsequent load from 0x100 over prior 0x0 returns 0x0000BEEF.
- i_req and d_req held high continuously with STARVE_LIMIT=4:
  - Grants D,D,D,D,I,D,D,D,D,I….
  - Each I grant is followed by i_rvalid, and rvalid never goes to the wrong owner.
- Alternating single-cycle loads D(0x200), I(0x4), D(0x204):
  - Three consecutive grants, with the rvalids on the matching port in consecutive cycles.
  - Each rdata matches the preloaded memory.
- Assert rst in the cycle after a D load grant:
  - d_rvalid stays 0 and starve_cnt=0.
  - The first post-reset i_req is granted immediately.
- No requests for 5 cycles: mem_en=0, all gnt and rvalid outputs 0, starve_cnt stays 0.
